ob_fifo_control: RTL and testbench

- Writeback-direction counterpart of the bias-load path: streams N words out of an on-chip output buffer (BRAM, 1-cycle read latency) into the DDR write FIFO.
- Also issues the DDR write-burst configuration (start address, byte length) to the DDR write engine.
- Sits between the PE output buffer banks and the DDR write FIFO; one transfer per conf pulse.

---
 rtl/ob_fifo_control_pkg.sv | 42 ++++
 rtl/ob_skid_fifo.sv | 69 ++++++
 rtl/ob_fifo_control.sv | 197 +++++++++++++++++++
 tb/tb_ob_fifo_control.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ob_fifo_control_pkg.sv
// -----------------------------------------------------------------------------
// ob_fifo_control_pkg
// Shared definitions for the output-buffer / bias-buffer FIFO controllers:
//   - clogb2         : ceil(log2(value)) for sizing counters and pointers
//   - buffer_num_calc: number of DATA_LEN-wide banks read in parallel
//   - SKID_*         : depth and field widths of the return-data skid FIFO
//   - xfer_state_t   : transfer FSM encoding (IDLE / RUN / DRAIN)
// -----------------------------------------------------------------------------
package ob_fifo_control_pkg;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clogb2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // A PE column produces one byte per word, so a word is 8*X_PE bits wide,
    // spread over as many DATA_LEN-wide banks as it takes.
    function automatic int buffer_num_calc(input int x_pe, input int data_len);
        return (8 * x_pe) / data_len;
    endfunction

    // Two entries cover the worst case: one word already parked plus one read
    // still in flight from the BRAM when the DDR FIFO stalls.
    localparam int SKID_DEPTH = 2;
    localparam int SKID_PTR_W = clogb2(SKID_DEPTH);
    localparam int SKID_CNT_W = clogb2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } xfer_state_t;

endpackage

// File: rtl/ob_skid_fifo.sv
// -----------------------------------------------------------------------------
// ob_skid_fifo
// Small SKID_DEPTH-entry FIFO that parks BRAM return data while the DDR write
// FIFO is full. Simultaneous push and pop are allowed. The head entry is shown
// combinationally so the controller can write it out in the same cycle.
// Ports:
//   clk, srst  : clock, synchronous active-high reset (empties the FIFO)
//   push       : store push_data
//   push_data  : word to store
//   pop        : discard the head entry
//   head       : oldest stored word (valid when count != 0)
//   count      : number of stored words
// -----------------------------------------------------------------------------
module ob_skid_fifo
    import ob_fifo_control_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic [SKID_CNT_W-1:0] count
);

    logic [WIDTH-1:0]      mem_reg [SKID_DEPTH];
    logic [SKID_PTR_W-1:0] wr_ptr_reg;
    logic [SKID_PTR_W-1:0] rd_ptr_reg;
    logic [SKID_CNT_W-1:0] count_reg;

    // Storage carries no reset; only the pointers and the count define what
    // is valid.
    genvar gi;
    generate
        for (gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == SKID_PTR_W'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + SKID_PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + SKID_PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + SKID_CNT_W'(1);
                2'b01:   count_reg <= count_reg - SKID_CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/ob_fifo_control.sv
// -----------------------------------------------------------------------------
// ob_fifo_control
// Streams word_num words from the on-chip output buffer (BRAM, 1-cycle read
// latency) into the DDR write FIFO, and issues the matching DDR write-burst
// configuration (start address, byte length). One transfer per conf pulse.
// Ports:
//   clk, rst         : clock, synchronous active-high reset (aborts a transfer)
//   conf             : start pulse, honoured only while idle
//   word_num         : number of words (buffer addresses) to move
//   ddr_byte         : DDR burst length in bytes
//   ddr_st_addr      : DDR destination start address
//   ob_st_addr       : output-buffer start address
//   ddr_st_addr_out  : latched DDR start address
//   ddr_len          : latched DDR byte length
//   ddr_conf         : one-cycle burst-config pulse (cycle after conf)
//   ob_addr, ob_en   : buffer read address / enable (all banks)
//   ob_data          : buffer read data, valid one cycle after ob_en
//   ddr_fifo_full    : DDR write FIFO full
//   ddr_fifo_wr      : DDR write FIFO strobe
//   ddr_fifo_data    : DDR write FIFO data
//   idle             : no transfer in progress
//   done             : one-cycle completion pulse
// -----------------------------------------------------------------------------
module ob_fifo_control
    import ob_fifo_control_pkg::*;
#(
    parameter int X_PE         = 16,
    parameter int DDR_ADDR_LEN = 32,
    parameter int ADDR_LEN     = 16,
    parameter int DATA_LEN     = 64,
    parameter int SINGLE_LEN   = 24,
    parameter int BUFFER_NUM   = buffer_num_calc(X_PE, DATA_LEN)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           conf,
    input  logic [SINGLE_LEN-1:0]          word_num,
    input  logic [SINGLE_LEN-1:0]          ddr_byte,
    input  logic [DDR_ADDR_LEN-1:0]        ddr_st_addr,
    input  logic [ADDR_LEN-1:0]            ob_st_addr,
    output logic [DDR_ADDR_LEN-1:0]        ddr_st_addr_out,
    output logic [SINGLE_LEN-1:0]          ddr_len,
    output logic                           ddr_conf,
    output logic [ADDR_LEN-1:0]            ob_addr,
    output logic                           ob_en,
    input  logic [DATA_LEN*BUFFER_NUM-1:0] ob_data,
    input  logic                           ddr_fifo_full,
    output logic                           ddr_fifo_wr,
    output logic [DATA_LEN*BUFFER_NUM-1:0] ddr_fifo_data,
    output logic                           idle,
    output logic                           done
);

    localparam int BUS_W = DATA_LEN * BUFFER_NUM;

    xfer_state_t             state_reg, state_next;
    logic [SINGLE_LEN-1:0]   word_num_reg;
    logic [SINGLE_LEN-1:0]   reads_reg;
    logic [SINGLE_LEN-1:0]   writes_reg;
    logic [ADDR_LEN-1:0]     ob_addr_reg;
    logic [DDR_ADDR_LEN-1:0] ddr_addr_reg;
    logic [SINGLE_LEN-1:0]   ddr_len_reg;
    logic                    ddr_conf_reg;
    logic                    in_flight_reg;
    logic                    zero_done_reg;

    logic                    start;
    logic                    zero_start;
    logic                    finish;
    logic                    credit_ok;
    logic                    rd_issue;
    logic                    wr_fire;
    logic                    skid_empty;
    logic                    skid_push;
    logic                    skid_pop;
    logic [BUS_W-1:0]        skid_head;
    logic [SKID_CNT_W-1:0]   skid_count;
    logic [SKID_CNT_W:0]     outstanding;

    // Words owed to the DDR side: parked in the skid buffer plus the one read
    // whose data appears on ob_data this cycle. Keeping this below the skid
    // depth means a stalled DDR FIFO can never overflow the skid buffer.
    assign outstanding = {1'b0, skid_count} + (SKID_CNT_W + 1)'(in_flight_reg);
    assign credit_ok   = outstanding < (SKID_CNT_W + 1)'(SKID_DEPTH);

    assign rd_issue = ~rst && (state_reg == ST_RUN)
                      && (reads_reg != word_num_reg) && credit_ok;

    // Returning data bypasses the skid storage when nothing is parked, which
    // gives the one-cycle read-to-write path; the skid buffer only fills when
    // the DDR FIFO pushes back.
    assign skid_empty = (skid_count == '0);
    assign wr_fire    = ~rst && (~skid_empty || in_flight_reg) && ~ddr_fifo_full;
    assign skid_pop   = wr_fire && ~skid_empty;
    assign skid_push  = in_flight_reg && ~(skid_empty && wr_fire);

    always_comb begin
        ddr_fifo_data = '0;
        if (!skid_empty) begin
            ddr_fifo_data = skid_head;
        end else if (in_flight_reg) begin
            ddr_fifo_data = ob_data;
        end
    end

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        zero_start = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (rd_issue && (reads_reg == word_num_reg - SINGLE_LEN'(1))) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (writes_reg == word_num_reg) begin
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = state_reg;
            end
        endcase
        // The finishing cycle already reports idle, so a conf arriving there
        // is accepted exactly as it would be in IDLE.
        if (conf && ((state_reg == ST_IDLE) || finish)) begin
            if (word_num != '0) begin
                start      = 1'b1;
                state_next = ST_RUN;
            end else begin
                zero_start = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            word_num_reg  <= '0;
            reads_reg     <= '0;
            writes_reg    <= '0;
            ob_addr_reg   <= '0;
            ddr_addr_reg  <= '0;
            ddr_len_reg   <= '0;
            ddr_conf_reg  <= 1'b0;
            in_flight_reg <= 1'b0;
            zero_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ddr_conf_reg  <= start;
            in_flight_reg <= rd_issue;
            zero_done_reg <= zero_start;
            if (start) begin
                word_num_reg <= word_num;
                ob_addr_reg  <= ob_st_addr;
                ddr_addr_reg <= ddr_st_addr;
                ddr_len_reg  <= ddr_byte;
                reads_reg    <= '0;
                writes_reg   <= '0;
            end else begin
                // ob_addr wraps naturally at 2^ADDR_LEN.
                if (rd_issue) begin
                    ob_addr_reg <= ob_addr_reg + ADDR_LEN'(1);
                    reads_reg   <= reads_reg + SINGLE_LEN'(1);
                end
                if (wr_fire) begin
                    writes_reg <= writes_reg + SINGLE_LEN'(1);
                end
            end
        end
    end

    ob_skid_fifo #(
        .WIDTH (BUS_W)
    ) u_skid (
        .clk       (clk),
        .srst      (rst),
        .push      (skid_push),
        .push_data (ob_data),
        .pop       (skid_pop),
        .head      (skid_head),
        .count     (skid_count)
    );

    assign ddr_st_addr_out = ddr_addr_reg;
    assign ddr_len         = ddr_len_reg;
    assign ddr_conf        = ddr_conf_reg;
    assign ob_addr         = ob_addr_reg;
    assign ob_en           = rd_issue;
    assign ddr_fifo_wr     = wr_fire;
    assign idle            = (state_reg == ST_IDLE) || finish;
    assign done            = ~rst && (finish || zero_done_reg);

endmodule

// File: tb/tb_ob_fifo_control.sv
// -----------------------------------------------------------------------------
// tb_ob_fifo_control
// Self-checking bench for ob_fifo_control: a table of directed transfers, a
// randomized batch with random DDR back-pressure, and hand-written sequences
// for conf re-pulse and mid-transfer reset. Expected behaviour comes from a
// transfer-level model: address i of a transfer is ob_st_addr+i (mod 2^16),
// the i-th DDR write carries the buffer contents at that address, and done
// follows the last write.
// -----------------------------------------------------------------------------
module tb_ob_fifo_control;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         conf = 1'b0;
    logic [23:0]  word_num = '0;
    logic [23:0]  ddr_byte = '0;
    logic [31:0]  ddr_st_addr = '0;
    logic [15:0]  ob_st_addr = '0;
    logic [31:0]  ddr_st_addr_out;
    logic [23:0]  ddr_len;
    logic         ddr_conf;
    logic [15:0]  ob_addr;
    logic         ob_en;
    logic [127:0] ob_data = '0;
    logic         ddr_fifo_full = 1'b0;
    logic         ddr_fifo_wr;
    logic [127:0] ddr_fifo_data;
    logic         idle;
    logic         done;

    int           checks = 0;
    int           failures = 0;
    logic [31:0]  salt = 32'h0;

    ob_fifo_control dut (
        .clk             (clk),
        .rst             (rst),
        .conf            (conf),
        .word_num        (word_num),
        .ddr_byte        (ddr_byte),
        .ddr_st_addr     (ddr_st_addr),
        .ob_st_addr      (ob_st_addr),
        .ddr_st_addr_out (ddr_st_addr_out),
        .ddr_len         (ddr_len),
        .ddr_conf        (ddr_conf),
        .ob_addr         (ob_addr),
        .ob_en           (ob_en),
        .ob_data         (ob_data),
        .ddr_fifo_full   (ddr_fifo_full),
        .ddr_fifo_wr     (ddr_fifo_wr),
        .ddr_fifo_data   (ddr_fifo_data),
        .idle            (idle),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Buffer contents as a function of address (and a per-transfer salt).
    function automatic logic [127:0] pat(input logic [15:0] a);
        logic [31:0] h;
        h = {a, ~a} ^ salt;
        return {h, h * 32'h9E37_79B1, ~h, h + 32'h1234_5678};
    endfunction

    // Output buffer BRAM: one-cycle read latency.
    always @(posedge clk) begin
        if (ob_en) begin
            ob_data <= pat(ob_addr);
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr_out"}, ddr_st_addr_out, 0);
        check({tag, "_len"}, ddr_len, 0);
        check({tag, "_ddr_conf"}, ddr_conf, 0);
        check({tag, "_ob_addr"}, ob_addr, 0);
        check({tag, "_ob_en"}, ob_en, 0);
        check({tag, "_wr"}, ddr_fifo_wr, 0);
        check({tag, "_wr_data"}, ddr_fifo_data, 0);
        check({tag, "_idle"}, idle, 1);
        check({tag, "_done"}, done, 0);
    endtask

    // mode 0: never full, 1: full on cycles 2..6, 2: random full.
    // exp_done < 0 means the done cycle is not fixed in advance.
    task automatic run_transfer(input int wn, input logic [15:0] st, input logic [31:0] da,
                                input int mode, input bit repulse, input int exp_done);
        int  reads, writes, w_before, confs, dones, done_cyc;
        bit  finished, exp_fin;
        reads = 0; writes = 0; confs = 0; dones = 0; done_cyc = -1; finished = 0;
        salt = $urandom;
        @(negedge clk);
        word_num      = 24'(wn);
        ddr_byte      = 24'(wn * 16);
        ddr_st_addr   = da;
        ob_st_addr    = st;
        ddr_fifo_full = 1'b0;
        conf          = 1'b1;
        for (int c = 1; c <= 300 && !finished; c++) begin
            @(negedge clk);
            conf = 1'b0;
            if (repulse && c == 2) begin
                conf        = 1'b1;
                word_num    = 24'd7;
                ob_st_addr  = st ^ 16'h5555;
                ddr_st_addr = ~da;
                ddr_byte    = 24'd112;
            end
            case (mode)
                0:       ddr_fifo_full = 1'b0;
                1:       ddr_fifo_full = (c >= 2 && c <= 6);
                default: ddr_fifo_full = ($urandom_range(0, 2) == 0);
            endcase
            #1;
            w_before = writes;
            if (wn != 0) begin
                check("latched_addr", ddr_st_addr_out, da);
                check("latched_len", ddr_len, 24'(wn * 16));
            end
            if (ddr_conf) begin
                confs++;
                check("conf_cycle", c, 1);
            end
            if (ob_en) begin
                check("rd_addr", ob_addr, 16'(st + 16'(reads)));
                check("rd_credit", (reads - writes) < 2, 1);
                if (mode == 0) check("rd_cycle", c, reads + 1);
                reads++;
            end
            if (ddr_fifo_wr) begin
                check("wr_while_full", ddr_fifo_full, 0);
                check("wr_data", ddr_fifo_data, pat(16'(st + 16'(writes))));
                if (mode == 0) check("wr_cycle", c, writes + 2);
                writes++;
            end
            exp_fin = (w_before == wn);
            check("done", done, exp_fin);
            check("idle", idle, exp_fin || (wn == 0));
            if (done) begin
                dones++;
                done_cyc = c;
            end
            finished = done || exp_fin;
        end
        check("reads_total", reads, wn);
        check("writes_total", writes, wn);
        check("conf_count", confs, (wn != 0));
        check("done_count", dones, 1);
        if (exp_done >= 0) check("done_cycle", done_cyc, exp_done);
        ddr_fifo_full = 1'b0;
        for (int q = 0; q < 3; q++) begin
            @(negedge clk);
            #1;
            check("quiet_ob_en", ob_en, 0);
            check("quiet_wr", ddr_fifo_wr, 0);
            check("quiet_done", done, 0);
            check("quiet_conf", ddr_conf, 0);
            check("quiet_idle", idle, 1);
        end
        $display("xfer wn=%0d st=%h ddr=%h mode=%0d repulse=%0d reads=%0d writes=%0d done_cycle=%0d",
                 wn, st, da, mode, repulse, reads, writes, done_cyc);
    endtask

    typedef struct {
        int          wn;
        logic [15:0] st;
        logic [31:0] da;
        int          mode;
        bit          repulse;
        int          exp_done;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{4, 16'h0010, 32'h1000_0000, 0, 1'b0, 6};
        vecs[1] = '{4, 16'h0010, 32'h1000_0000, 1, 1'b0, 11};
        vecs[2] = '{0, 16'h0010, 32'h1000_0000, 0, 1'b0, 1};
        vecs[3] = '{4, 16'hFFFE, 32'h1000_0400, 0, 1'b0, 6};
        vecs[4] = '{1, 16'h1234, 32'h0000_0040, 0, 1'b0, 3};
        vecs[5] = '{8, 16'h0100, 32'h2000_0000, 0, 1'b0, 10};
        vecs[6] = '{4, 16'h0020, 32'h2000_1000, 0, 1'b1, 6};

        // Reset state.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst0");
        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            run_transfer(vecs[i].wn, vecs[i].st, vecs[i].da, vecs[i].mode,
                         vecs[i].repulse, vecs[i].exp_done);
        end

        // Reset in the middle of an 8-word transfer.
        salt = $urandom;
        @(negedge clk);
        word_num    = 24'd8;
        ddr_byte    = 24'd128;
        ddr_st_addr = 32'h3000_0000;
        ob_st_addr  = 16'h0040;
        conf        = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            conf = 1'b0;
            if (c == 3) rst = 1'b1;
            if (c == 4) begin
                #1;
                check_reset_outputs("abort");
                rst = 1'b0;
            end
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            check("abort_ob_en", ob_en, 0);
            check("abort_wr", ddr_fifo_wr, 0);
            check("abort_done", done, 0);
            check("abort_idle", idle, 1);
        end
        $display("xfer abort wn=8 st=0040 rst at cycle 3");
        run_transfer(4, 16'h0010, 32'h1000_0000, 0, 1'b0, 6);

        // Randomized transfers with random back-pressure.
        for (int i = 0; i < 25; i++) begin
            run_transfer($urandom_range(1, 24), 16'($urandom), $urandom, 2, 1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
